// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider dispatch front-end.
//   state_t  - dispatch FSM states
//   DZ_COC   - quotient reported for a divide-by-zero (all ones, sliced to WIDTH)
//   min_val  - most negative two's-complement value for a given width
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // Widest operand the constants below can describe.
    localparam int MAX_W = 64;

    localparam logic [MAX_W-1:0] DZ_COC = '1;

    function automatic logic [MAX_W-1:0] min_val(input int w);
        min_val = MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/div_fifo.sv
// div_fifo: synchronous FIFO holding operand pairs awaiting the divider.
// Ports:
//   CLK, RSTa       clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data   write request and data (ignored when full)
//   pop             read request (ignored when empty); rd_data shows the head
//   full, empty     occupancy flags
module div_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTa,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/div_dispatch.sv
// div_dispatch: buffers signed operand pairs, issues them one at a time to a
// sequential divider and returns quotient/remainder over valid/ready.
// Divide-by-zero and MIN/-1 are resolved here without starting the divider.
// The divider shares RSTa, so a reset clears both sides together.
// Ports:
//   CLK, RSTa                         clock, asynchronous active-low reset
//   in_valid/in_ready/in_num/in_den   operand input handshake
//   div_start/div_num/div_den         divider request (operands held until done)
//   div_done/div_coc/div_res          divider completion
//   out_valid/out_ready/out_coc/out_res/out_dz/out_ovf  result handshake
//   busy                              work buffered or in progress
module div_dispatch
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RSTa,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             div_start,
    output logic [WIDTH-1:0] div_num,
    output logic [WIDTH-1:0] div_den,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_coc,
    input  logic [WIDTH-1:0] div_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_coc,
    output logic [WIDTH-1:0] out_res,
    output logic             out_dz,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [MAX_W-1:0] MIN_FULL = min_val(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V    = MIN_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] DZ_V     = DZ_COC[WIDTH-1:0];

    state_t             state;
    state_t             state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_num;
    logic [WIDTH-1:0]   head_den;
    logic               head_dz;
    logic               head_ovf;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // In IDLE out_valid is always low, so a non-empty FIFO is enough to pop.
    assign pop      = (state == IDLE) && !fifo_empty;
    assign head_num = head[2*WIDTH-1:WIDTH];
    assign head_den = head[WIDTH-1:0];
    assign head_dz  = (head_den == '0);
    assign head_ovf = (head_num == MIN_V) && (head_den == '1);
    assign busy     = !fifo_empty || (state != IDLE);

    div_fifo #(
        .WIDTH (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RSTa    (RSTa),
        .push    (push),
        .wr_data ({in_num, in_den}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_dz || head_ovf)
                        state_next = OUTPUT;
                    else
                        state_next = ISSUE;
                end
            end
            ISSUE:  state_next = WAIT;
            WAIT:   if (div_done) state_next = OUTPUT;
            OUTPUT: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        div_start = (state == ISSUE);
        out_valid = (state == OUTPUT);
    end

    // Operand and result registers. Results only change on a pop (special
    // cases) or on a done seen in WAIT, so they hold throughout OUTPUT.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            div_num <= '0;
            div_den <= '0;
            out_coc <= '0;
            out_res <= '0;
            out_dz  <= 1'b0;
            out_ovf <= 1'b0;
        end else if (pop) begin
            div_num <= head_num;
            div_den <= head_den;
            if (head_dz) begin
                out_coc <= DZ_V;
                out_res <= head_num;
                out_dz  <= 1'b1;
                out_ovf <= 1'b0;
            end else if (head_ovf) begin
                out_coc <= MIN_V;
                out_res <= '0;
                out_dz  <= 1'b0;
                out_ovf <= 1'b1;
            end
        end else if ((state == WAIT) && div_done) begin
            out_coc <= div_coc;
            out_res <= div_res;
            out_dz  <= 1'b0;
            out_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_dispatch.sv
// tb_div_dispatch: scoreboard bench for div_dispatch with a behavioural
// sequential divider attached to the div_* ports.
module tb_div_dispatch;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 2*WIDTH + 3;

    typedef struct packed {
        logic [WIDTH-1:0] coc;
        logic [WIDTH-1:0] res;
        logic             dz;
        logic             ovf;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RSTa = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_num = '0;
    logic [WIDTH-1:0] in_den = '0;
    logic             div_start;
    logic [WIDTH-1:0] div_num;
    logic [WIDTH-1:0] div_den;
    logic             div_done;
    logic [WIDTH-1:0] div_coc;
    logic [WIDTH-1:0] div_res;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_coc;
    logic [WIDTH-1:0] out_res;
    logic             out_dz;
    logic             out_ovf;
    logic             busy;

    int   checks = 0;
    int   passes = 0;
    int   start_cnt = 0;
    int   acc_cnt = 0;
    int   overlap_err = 0;
    int   hold_err = 0;
    exp_t exp_q[$];

    div_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RSTa      (RSTa),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .div_start (div_start),
        .div_num   (div_num),
        .div_den   (div_den),
        .div_done  (div_done),
        .div_coc   (div_coc),
        .div_res   (div_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coc   (out_coc),
        .out_res   (out_res),
        .out_dz    (out_dz),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv)
            passes++;
        else
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    endtask

    // Behavioural divider: fixed latency, truncating signed division.
    int               dcnt;
    logic [WIDTH-1:0] dn, dd;
    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            dcnt     <= 0;
            div_done <= 1'b0;
            div_coc  <= '0;
            div_res  <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                if (dcnt != 0 || div_done) overlap_err++;
                start_cnt++;
                dn   <= div_num;
                dd   <= div_den;
                dcnt <= LAT;
            end else if (dcnt != 0) begin
                if (div_num !== dn || div_den !== dd) hold_err++;
                if (dcnt == 1) begin
                    div_done <= 1'b1;
                    div_coc  <= $signed(dn) / $signed(dd);
                    div_res  <= $signed(dn) % $signed(dd);
                end
                dcnt <= dcnt - 1;
            end
        end
    end

    always @(posedge CLK)
        if (RSTa && in_valid && in_ready) acc_cnt++;

    // Monitor: compare every accepted result against the scoreboard head.
    always @(negedge CLK) begin
        if (RSTa && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_coc", out_coc, e.coc);
                chk("out_res", out_res, e.res);
                chk("out_dz",  out_dz,  e.dz);
                chk("out_ovf", out_ovf, e.ovf);
            end
        end
    end

    task automatic push(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] qc, input logic [WIDTH-1:0] qr,
                        input logic dz, input logic ovf);
        int k = 0;
        exp_t e;
        e = '{coc: qc, res: qr, dz: dz, ovf: ovf};
        in_valid = 1'b1;
        in_num   = n;
        in_den   = d;
        while (!in_ready && k < 1000) begin
            @(posedge CLK); #1;
            k++;
        end
        if (k >= 1000) chk("push_timeout", 1, 0);
        exp_q.push_back(e);
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 2000) begin
            @(posedge CLK); #1;
            k++;
        end
        chk("drain_timeout", (k < 2000), 1);
    endtask

    initial begin
        int s0, a0;
        logic [WIDTH-1:0] snap_coc, snap_res;

        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_busy",      busy,      0);
        chk("rst_div_start", div_start, 0);
        chk("rst_out_coc",   out_coc,   0);
        chk("rst_div_num",   div_num,   0);
        repeat (2) @(negedge CLK);
        RSTa = 1'b1;
        @(posedge CLK); #1;

        // 100/7 through the divider.
        s0 = start_cnt;
        push(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        drain();
        chk("start_100_7", start_cnt - s0, 1);

        // Back-to-back signed cases.
        s0 = start_cnt;
        push(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0);
        push(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b0);
        drain();
        chk("start_pair", start_cnt - s0, 2);

        // Divide by zero: bypass, 2-cycle latency.
        s0 = start_cnt;
        push(32'd55, 32'd0, 32'hFFFF_FFFF, 32'd55, 1'b1, 1'b0);
        chk("dz_lat_early", out_valid, 0);
        @(posedge CLK); #1;
        chk("dz_lat_valid", out_valid, 1);
        drain();
        chk("start_dz", start_cnt - s0, 0);

        // MIN / -1 overflow bypass.
        s0 = start_cnt;
        push(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        drain();
        chk("start_ovf", start_cnt - s0, 0);

        // Back-pressure: 5 accepted, 6th blocked while out_ready is low.
        out_ready = 1'b0;
        a0 = acc_cnt;
        push(32'd20, 32'd3, 32'd6, 32'd2, 1'b0, 1'b0);
        push(-32'sd9, 32'd2, -32'sd4, -32'sd1, 1'b0, 1'b0);
        push(32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0);
        push(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        push(-32'sd50, -32'sd6, 32'd8, -32'sd2, 1'b0, 1'b0);
        chk("bp_full", in_ready, 0);
        begin
            int k = 0;
            while (!out_valid && k < 500) begin
                @(posedge CLK); #1;
                k++;
            end
            chk("bp_first_timeout", (k < 500), 1);
        end
        snap_coc = out_coc;
        snap_res = out_res;
        fork
            push(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);
            begin
                repeat (200) @(posedge CLK);
                #1;
                chk("bp_accepted", acc_cnt - a0, 5);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_coc", out_coc, snap_coc);
                chk("bp_hold_res", out_res, snap_res);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while the divider is working.
        push(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
        begin
            int k = 0;
            while (!(dut.state == div_pkg::WAIT) && k < 100) begin
                @(posedge CLK); #1;
                k++;
            end
            chk("wait_timeout", (k < 100), 1);
        end
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        RSTa = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy",      busy,      0);
        chk("mid_rst_in_ready",  in_ready,  1);
        repeat (2) @(negedge CLK);
        RSTa = 1'b1;
        @(posedge CLK); #1;
        push(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 1'b0);
        drain();

        chk("start_overlap", overlap_err, 0);
        chk("operand_hold",  hold_err,    0);
        chk("queue_empty",   exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
